// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS   = 4;
    localparam int unsigned KP_COLS   = 4;
    localparam int unsigned KP_CODE_W = 4;
    localparam int unsigned KP_IDX_W  = 2;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_e;

    // Key code payload: {row_idx, col_idx}
    typedef struct packed {
        logic [KP_IDX_W-1:0] row;
        logic [KP_IDX_W-1:0] col;
    } kp_code_t;

    // One-cold column drive: only the selected column is pulled low
    function automatic logic [KP_COLS-1:0] col_pattern(input logic [KP_IDX_W-1:0] idx);
        col_pattern = ~(KP_COLS'(1) << idx);
    endfunction

endpackage

// File: rtl/keypad_row_encoder.sv
// Classifies an active-low row sample as a single press, idle or ghosted (invalid).
module keypad_row_encoder
    import keypad_pkg::*;
(
    input  logic [KP_ROWS-1:0]  key_row,
    output logic                press_c,
    output logic                invalid_c,
    output logic [KP_IDX_W-1:0] row_idx_c
);

    logic [2:0] n_low;

    always_comb begin
        n_low     = 3'd0;
        row_idx_c = '0;
        for (int unsigned r = 0; r < KP_ROWS; r++) begin
            if (!key_row[r]) begin
                n_low     = n_low + 3'd1;
                row_idx_c = KP_IDX_W'(r);
            end
        end
        press_c   = (n_low == 3'd1);
        invalid_c = (n_low > 3'd1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with press/release debounce and one-cycle accept pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 2,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic [KP_ROWS-1:0]   key_row,
    output logic [KP_COLS-1:0]   key_col,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_held
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SAMPLES);

    kp_state_e                state_q, state_d;
    logic [KP_IDX_W-1:0]      col_idx_q, col_idx_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic [DEB_W-1:0]         deb_q, deb_d;
    kp_code_t                 cand_q, cand_d;
    logic [KP_COLS-1:0]       key_col_q, key_col_d;
    logic [KP_CODE_W-1:0]     key_code_q, key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic                     key_held_q, key_held_d;

    logic                     press_c, invalid_c;
    logic [KP_IDX_W-1:0]      row_idx_c;
    logic                     sample_c, single_c, is_cand_c, deb_done_c;
    logic [DEB_W-1:0]         deb_inc_c;
    logic [KP_IDX_W-1:0]      col_next_c;

    keypad_row_encoder u_row_enc (
        .key_row   (key_row),
        .press_c   (press_c),
        .invalid_c (invalid_c),
        .row_idx_c (row_idx_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        deb_d       = deb_q;
        cand_d      = cand_q;
        key_col_d   = key_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        settle_d    = (settle_q == SET_LAST) ? '0 : settle_q + SET_W'(1);

        sample_c   = (settle_q == SET_LAST);
        // Ghosted samples never count as a press
        single_c   = press_c && !invalid_c;
        is_cand_c  = single_c && (row_idx_c == cand_q.row);
        deb_inc_c  = (deb_q == DEB_LAST) ? deb_q : deb_q + DEB_W'(1);
        deb_done_c = (deb_inc_c == DEB_LAST);
        col_next_c = col_idx_q + KP_IDX_W'(1);

        case (state_q)
            SCAN: begin
                if (sample_c) begin
                    if (single_c) begin
                        cand_d.row = row_idx_c;
                        cand_d.col = col_idx_q;
                        deb_d      = DEB_W'(1);
                        if (DEBOUNCE_SAMPLES == 1) begin
                            key_code_d  = {row_idx_c, col_idx_q};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_d       = '0;
                            state_d     = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_next_c;
                        key_col_d = col_pattern(col_next_c);
                    end
                end
            end
            DEBOUNCE: begin
                if (sample_c) begin
                    if (is_cand_c) begin
                        deb_d = deb_inc_c;
                        if (deb_done_c) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_d       = '0;
                            state_d     = HELD;
                        end
                    end else begin
                        deb_d     = '0;
                        col_idx_d = col_next_c;
                        key_col_d = col_pattern(col_next_c);
                        state_d   = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample_c && !is_cand_c) begin
                    if (DEBOUNCE_SAMPLES == 1) begin
                        key_held_d = 1'b0;
                        deb_d      = '0;
                        col_idx_d  = col_next_c;
                        key_col_d  = col_pattern(col_next_c);
                        state_d    = SCAN;
                    end else begin
                        deb_d   = DEB_W'(1);
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (sample_c) begin
                    if (is_cand_c) begin
                        deb_d   = '0;
                        state_d = HELD;
                    end else begin
                        deb_d = deb_inc_c;
                        if (deb_done_c) begin
                            key_held_d = 1'b0;
                            deb_d      = '0;
                            col_idx_d  = col_next_c;
                            key_col_d  = col_pattern(col_next_c);
                            state_d    = SCAN;
                        end
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            settle_q    <= '0;
            deb_q       <= '0;
            cand_q      <= '0;
            key_col_q   <= col_pattern('0);
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            settle_q    <= settle_d;
            deb_q       <= deb_d;
            cand_q      <= cand_d;
            key_col_q   <= key_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_col   = key_col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    logic        clk_div = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_div = ~clk_div;

    // Key matrix: bit r*4+c closed pulls row r low while column c is driven low
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    keypad_scanner #(
        .SETTLE_CYCLES    (2),
        .DEBOUNCE_SAMPLES (4)
    ) dut (
        .clk_div   (clk_div),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Leaves the bench on a falling edge just before the first active edge after reset
    task automatic do_reset();
        rst     = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk_div);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] walk [9];
        walk = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                 4'b0111, 4'b0111, 4'b1110};
        do_reset();
        vectors++;
        if ({key_code, key_valid, key_held} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: code=%h valid=%b held=%b expected 0 0 0", key_code, key_valid, key_held);
        end
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk_div);
            vectors++;
            if (key_col !== walk[k]) begin
                miscompares++;
                $display("FAIL reset_walk[%0d]: key_col=%b expected %b", k, key_col, walk[k]);
            end
        end
        repeat (2) @(negedge clk_div);
        rst = 1'b1;
        #1;
        vectors++;
        if ({key_col, key_valid, key_held} !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_async: col=%b valid=%b held=%b expected 1110 0 0", key_col, key_valid, key_held);
        end
        @(negedge clk_div);
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int pulses;
        pulses = 0;
        do_reset();
        for (int j = 1; j <= 62; j++) begin
            pressed[9] = (j <= 50);
            @(negedge clk_div);
            if (key_valid === 1'b1) pulses++;
            vectors++;
            if (key_valid !== (j == 10)) begin
                miscompares++;
                $display("FAIL press_valid@%0d: key_valid=%b expected %b", j, key_valid, (j == 10));
            end
            if (j == 10 || j == 30) begin
                vectors++;
                if (key_code !== 4'h9 || key_held !== 1'b1 || key_col !== 4'b1101) begin
                    miscompares++;
                    $display("FAIL press_accept@%0d: code=%h held=%b col=%b expected 9 1 1101", j, key_code, key_held, key_col);
                end
            end
            if (j == 57) begin
                vectors++;
                if (key_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL press_held_before_drop: key_held=%b expected 1", key_held);
                end
            end
            if (j == 58 || j == 59) begin
                vectors++;
                if (key_held !== 1'b0 || key_col !== 4'b1011 || key_code !== 4'h9) begin
                    miscompares++;
                    $display("FAIL press_release@%0d: held=%b col=%b code=%h expected 0 1011 9", j, key_held, key_col, key_code);
                end
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL press_pulse_count: pulses=%0d expected 1", pulses);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int j = 1; j <= 40; j++) begin
            pressed[3] = (j <= 8) || (j >= 11 && j <= 18) || (j >= 21);
            @(negedge clk_div);
            vectors++;
            if (key_valid !== (j == 34)) begin
                miscompares++;
                $display("FAIL bounce_valid@%0d: key_valid=%b expected %b", j, key_valid, (j == 34));
            end
            if (j == 34) begin
                vectors++;
                if (key_code !== 4'h3 || key_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bounce_accept: code=%h held=%b expected 3 1", key_code, key_held);
                end
            end
        end
    endtask

    task automatic test_ghost();
        logic [3:0] exp_col;
        do_reset();
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk_div);
            exp_col = 4'b0001 << ((j / 2) % 4);
            exp_col = ~exp_col;
            vectors++;
            if (key_valid !== 1'b0 || key_held !== 1'b0 || key_col !== exp_col) begin
                miscompares++;
                $display("FAIL ghost@%0d: valid=%b held=%b col=%b expected 0 0 %b", j, key_valid, key_held, key_col, exp_col);
            end
        end
    endtask

    task automatic test_release_chatter();
        do_reset();
        for (int j = 1; j <= 50; j++) begin
            pressed[9] = (j <= 13) || (j >= 17 && j <= 40);
            @(negedge clk_div);
            vectors++;
            if (key_valid !== (j == 10)) begin
                miscompares++;
                $display("FAIL chatter_valid@%0d: key_valid=%b expected %b", j, key_valid, (j == 10));
            end
            if (j >= 10 && j <= 47) begin
                vectors++;
                if (key_held !== 1'b1 || key_col !== 4'b1101) begin
                    miscompares++;
                    $display("FAIL chatter_held@%0d: held=%b col=%b expected 1 1101", j, key_held, key_col);
                end
            end
            if (j == 48) begin
                vectors++;
                if (key_held !== 1'b0 || key_col !== 4'b1011) begin
                    miscompares++;
                    $display("FAIL chatter_drop: held=%b col=%b expected 0 1011", key_held, key_col);
                end
            end
        end
    endtask

    task automatic test_two_keys();
        do_reset();
        pressed[14] = 1'b1;
        for (int j = 1; j <= 42; j++) begin
            pressed[4] = (j <= 20);
            @(negedge clk_div);
            vectors++;
            if (key_valid !== (j == 8 || j == 38)) begin
                miscompares++;
                $display("FAIL two_valid@%0d: key_valid=%b expected %b", j, key_valid, (j == 8 || j == 38));
            end
            if (j == 8 || j == 20) begin
                vectors++;
                if (key_code !== 4'h4 || key_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL two_first@%0d: code=%h held=%b expected 4 1", j, key_code, key_held);
                end
            end
            if (j == 30) begin
                vectors++;
                if (key_code !== 4'h4 || key_held !== 1'b0) begin
                    miscompares++;
                    $display("FAIL two_released: code=%h held=%b expected 4 0", key_code, key_held);
                end
            end
            if (j == 38) begin
                vectors++;
                if (key_code !== 4'hE || key_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL two_second: code=%h held=%b expected e 1", key_code, key_held);
                end
            end
        end
    endtask

    task automatic test_reset_mid_held();
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL midheld_pre: key_held=%b expected 1", key_held);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({key_col, key_code, key_valid, key_held} !== 10'b1110_0000_00) begin
            miscompares++;
            $display("FAIL midheld_async: col=%b code=%h valid=%b held=%b expected 1110 0 0 0", key_col, key_code, key_valid, key_held);
        end
        @(negedge clk_div);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        pressed = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_release_chatter();
        test_two_keys();
        test_reset_mid_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
